// File: rtl/alu8_rr_arbiter_if.sv
// Request/response bundle between the requesting engines and the shared ALU.
// Requesters sit on the master side; the arbiter is the slave.
interface alu8_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [3*NREQ-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_y;
  logic              rsp_z;
  logic              rsp_c;
  logic              rsp_v;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y,
    input  rsp_z, rsp_c, rsp_v
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y,
    output rsp_z, rsp_c, rsp_v
  );
endinterface

// File: rtl/alu8_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU among NREQ
// requesters; one operation at a time through IDLE -> EXEC -> RESP.

// 8-bit ALU. C is carry for add, borrow for sub, the shifted-out bit for
// shifts and 0 otherwise; V is signed overflow for add/sub, else 0.
module alu8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] y_o,
  output logic       z_o,
  output logic       c_o,
  output logic       v_o
);
  logic [8:0] sum;
  logic [8:0] dif;

  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i};
  assign z_o = (y_o == 8'h00);

  // Opcode decode
  always_comb begin
    y_o = 8'h00;
    c_o = 1'b0;
    v_o = 1'b0;
    unique case (op_i)
      3'b000: begin
        y_o = sum[7:0];
        c_o = sum[8];
        v_o = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
      end
      3'b001: begin
        y_o = dif[7:0];
        c_o = dif[8];
        v_o = (a_i[7] != b_i[7]) && (dif[7] != a_i[7]);
      end
      3'b010: y_o = a_i & b_i;
      3'b011: y_o = a_i | b_i;
      3'b100: y_o = a_i ^ b_i;
      3'b101: begin
        y_o = {a_i[6:0], 1'b0};
        c_o = a_i[7];
      end
      3'b110: begin
        y_o = {1'b0, a_i[7:1]};
        c_o = a_i[0];
      end
      3'b111: y_o = a_i;
      default: y_o = 8'h00;
    endcase
  end
endmodule

module alu8_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  alu8_rr_arbiter_if.slave    bus,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     a_q;
  logic [7:0]     b_q;
  logic [2:0]     op_q;
  logic           busy_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [7:0]     rsp_y_q;
  logic           rsp_z_q;
  logic           rsp_c_q;
  logic           rsp_v_q;

  logic           win_vld;
  logic [IDW-1:0] win_idx;
  logic [7:0]     sel_a;
  logic [7:0]     sel_b;
  logic [2:0]     sel_op;
  logic [NREQ-1:0] rdy;

  logic [7:0]     alu_y;
  logic           alu_z;
  logic           alu_c;
  logic           alu_v;

  // Winner search from last_grant+1 upward; smallest distance wins
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((((int'(last_q) + k) % NREQ) == i) && bus.req_valid[i]) begin
          win_vld = 1'b1;
          win_idx = IDW'(i);
        end
      end
    end
  end

  // Winner operand mux and one-hot grant, only offered in IDLE
  always_comb begin
    sel_a  = 8'h00;
    sel_b  = 8'h00;
    sel_op = 3'b000;
    rdy    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_a  = bus.req_a[8*i +: 8];
        sel_b  = bus.req_b[8*i +: 8];
        sel_op = bus.req_op[3*i +: 3];
      end
      rdy[i] = rst_n && win_vld && (state_q == IDLE)
             && (win_idx == IDW'(i));
    end
  end

  alu8 u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y),
    .z_o  (alu_z),
    .c_o  (alu_c),
    .v_o  (alu_v)
  );

  // Control FSM with registered response and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      op_q        <= 3'b000;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= 8'h00;
      rsp_z_q     <= 1'b0;
      rsp_c_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            last_q  <= win_idx;
            id_q    <= win_idx;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_z_q     <= alu_z;
          rsp_c_q     <= alu_c;
          rsp_v_q     <= alu_v;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = rdy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_v     = rsp_v_q;
  assign busy          = busy_q;
endmodule
